gray_counter: RTL and testbench



---
 rtl/bg_pkg.sv | 22 ++
 rtl/gb_conv.sv | 21 ++
 rtl/gray_counter.sv | 78 +++++++
 tb/tb_gray_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Binary/Gray conversion helpers shared by the counter and its bench.
// b2g: Gray code of a binary value. g2b: binary value of a Gray code
// (XOR prefix from the MSB). Both take a MAX_WIDTH argument; narrower
// values are zero-extended, and leading zeros do not disturb either mapping.
package bg_pkg;

   localparam int unsigned MAX_WIDTH = 32;

   function automatic logic [MAX_WIDTH-1:0] b2g(input logic [MAX_WIDTH-1:0] x);
      return x ^ (x >> 1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] g2b(input logic [MAX_WIDTH-1:0] x);
      logic [MAX_WIDTH-1:0] b;
      b[MAX_WIDTH-1] = x[MAX_WIDTH-1];
      for (int i = int'(MAX_WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ x[i];
      end
      return b;
   endfunction

endpackage : bg_pkg

// File: rtl/gb_conv.sv
// Combinational Gray-to-binary converter.
// Ports:
//   g    input  [size-1:0]  Gray-coded value
//   b_c  output [size-1:0]  binary value (combinational)
// Bit i of the result is the XOR of g[size-1:i]; XOR-ing in successively
// shifted copies of g builds that prefix for every bit at once.
module gb_conv #(
   parameter int unsigned size = 4
) (
   input  logic [size-1:0] g,
   output logic [size-1:0] b_c
);

   always_comb begin
      b_c = g;
      for (int unsigned s = 1; s < size; s++) begin
         b_c = b_c ^ (g >> s);
      end
   end

endmodule : gb_conv

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with binary or Gray synchronous load.
// Ports:
//   clk        input             rising-edge clock
//   rst        input             asynchronous active-high reset
//   en         input             count enable
//   up         input             1 = count up, 0 = count down
//   load       input             synchronous load, overrides en
//   load_gray  input             1 = load_val is Gray-coded, 0 = binary
//   load_val   input  [WIDTH-1:0] value to load
//   bin        output [WIDTH-1:0] registered binary count
//   gray       output [WIDTH-1:0] registered Gray code of bin
//   wrap       output            one-cycle pulse on the edge the count wraps
module gray_counter
   import bg_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned INIT  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic             load_gray,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(b2g(MAX_WIDTH'(INIT)));

   logic [WIDTH-1:0] load_bin_c;
   logic [WIDTH-1:0] next_bin_c;
   logic [WIDTH-1:0] next_gray_c;
   logic             next_wrap_c;

   // Gray-coded load values are decoded before they reach the count register.
   gb_conv #(
      .size (WIDTH)
   ) u_gb_conv (
      .g   (load_val),
      .b_c (load_bin_c)
   );

   // Next count and wrap flag, in load > count > hold priority.
   always_comb begin
      next_bin_c  = bin;
      next_wrap_c = 1'b0;
      if (load) begin
         next_bin_c = load_gray ? load_bin_c : load_val;
      end else if (en) begin
         if (up) begin
            next_bin_c  = bin + WIDTH'(1);
            next_wrap_c = (bin == '1);
         end else begin
            next_bin_c  = bin - WIDTH'(1);
            next_wrap_c = (bin == '0);
         end
      end
      next_gray_c = WIDTH'(b2g(MAX_WIDTH'(next_bin_c)));
   end

   // Gray is registered from the next binary value so both outputs stay in step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin  <= INIT_BIN;
         gray <= INIT_GRAY;
         wrap <= 1'b0;
      end else begin
         bin  <= next_bin_c;
         gray <= next_gray_c;
         wrap <= next_wrap_c;
      end
   end

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter (WIDTH=4), INIT=0 and INIT=5 instances.
module tb_gray_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic       load_gray;
   logic [3:0] load_val;
   logic [3:0] bin;
   logic [3:0] gray;
   logic       wrap;
   logic [3:0] bin5;
   logic [3:0] gray5;
   logic       wrap5;

   int passed;
   int total;

   logic [3:0] gray_seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000};

   gray_counter #(.WIDTH(4), .INIT(0)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_gray(load_gray), .load_val(load_val),
      .bin(bin), .gray(gray), .wrap(wrap)
   );

   gray_counter #(.WIDTH(4), .INIT(5)) dut5 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_gray(load_gray), .load_val(load_val),
      .bin(bin5), .gray(gray5), .wrap(wrap5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 1'b0; load_val = '0;
      #1;
      total++;
      if ({bin, gray, wrap} !== {4'b0000, 4'b0000, 1'b0})
         $display("FAIL reset_init0: bin/gray/wrap=%b/%b/%b expected 0000/0000/0", bin, gray, wrap);
      else passed++;
      total++;
      if ({bin5, gray5, wrap5} !== {4'b0101, 4'b0111, 1'b0})
         $display("FAIL reset_init5: bin/gray/wrap=%b/%b/%b expected 0101/0111/0", bin5, gray5, wrap5);
      else passed++;
      tick();
      total++;
      if ({bin, gray, wrap} !== {4'b0000, 4'b0000, 1'b0})
         $display("FAIL reset_held: bin/gray/wrap=%b/%b/%b expected 0000/0000/0", bin, gray, wrap);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_up_count();
      logic [3:0] prev;
      en = 1'b1; up = 1'b1;
      prev = gray;
      for (int k = 1; k <= 17; k++) begin
         tick();
         total++;
         if ({bin, gray, wrap} !== {4'(k % 16), gray_seq[k % 16], (k == 16)})
            $display("FAIL up_step%0d: bin/gray/wrap=%b/%b/%b expected %b/%b/%b",
                     k, bin, gray, wrap, 4'(k % 16), gray_seq[k % 16], (k == 16));
         else passed++;
         total++;
         if ($countones(gray ^ prev) != 1)
            $display("FAIL up_hamming%0d: gray %b -> %b, bit changes %0d expected 1",
                     k, prev, gray, $countones(gray ^ prev));
         else passed++;
         if (k == 1) begin
            total++;
            if ({bin5, gray5, wrap5} !== {4'b0110, 4'b0101, 1'b0})
               $display("FAIL up_init5: bin/gray/wrap=%b/%b/%b expected 0110/0101/0", bin5, gray5, wrap5);
            else passed++;
         end
         prev = gray;
      end
   endtask

   task automatic test_down_count();
      en = 1'b1; up = 1'b0;
      tick();
      total++;
      if ({bin, gray, wrap} !== {4'b0000, 4'b0000, 1'b0})
         $display("FAIL down_to0: bin/gray/wrap=%b/%b/%b expected 0000/0000/0", bin, gray, wrap);
      else passed++;
      tick();
      total++;
      if ({bin, gray, wrap} !== {4'b1111, 4'b1000, 1'b1})
         $display("FAIL down_wrap: bin/gray/wrap=%b/%b/%b expected 1111/1000/1", bin, gray, wrap);
      else passed++;
      tick();
      total++;
      if ({bin, gray, wrap} !== {4'b1110, 4'b1001, 1'b0})
         $display("FAIL down_after: bin/gray/wrap=%b/%b/%b expected 1110/1001/0", bin, gray, wrap);
      else passed++;
   endtask

   task automatic test_load();
      en = 1'b0; load = 1'b1;
      load_gray = 1'b0; load_val = 4'b1001;
      tick();
      total++;
      if ({bin, gray, wrap} !== {4'b1001, 4'b1101, 1'b0})
         $display("FAIL load_bin: bin/gray/wrap=%b/%b/%b expected 1001/1101/0", bin, gray, wrap);
      else passed++;
      load_gray = 1'b1; load_val = 4'b0000;
      tick();
      load_val = 4'b1101;
      tick();
      total++;
      if ({bin, gray, wrap} !== {4'b1001, 4'b1101, 1'b0})
         $display("FAIL load_gray1101: bin/gray/wrap=%b/%b/%b expected 1001/1101/0", bin, gray, wrap);
      else passed++;
      load_val = 4'b1000;
      tick();
      total++;
      if ({bin, gray, wrap} !== {4'b1111, 4'b1000, 1'b0})
         $display("FAIL load_gray1000: bin/gray/wrap=%b/%b/%b expected 1111/1000/0", bin, gray, wrap);
      else passed++;
      load = 1'b0; load_gray = 1'b0;
   endtask

   task automatic test_priority_hold();
      // bin is 1111 here: an up count would wrap, so the load must suppress it
      load = 1'b1; en = 1'b1; up = 1'b1; load_gray = 1'b0; load_val = 4'b0011;
      tick();
      total++;
      if ({bin, gray, wrap} !== {4'b0011, 4'b0010, 1'b0})
         $display("FAIL load_priority: bin/gray/wrap=%b/%b/%b expected 0011/0010/0", bin, gray, wrap);
      else passed++;
      load = 1'b0; en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if ({bin, gray, wrap} !== {4'b0011, 4'b0010, 1'b0})
            $display("FAIL hold%0d: bin/gray/wrap=%b/%b/%b expected 0011/0010/0", k, bin, gray, wrap);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_count();
      load = 1'b1; load_gray = 1'b0; load_val = 4'b0111;
      tick();
      load = 1'b0;
      total++;
      if ({bin, gray} !== {4'b0111, 4'b0100})
         $display("FAIL mid_preload: bin/gray=%b/%b expected 0111/0100", bin, gray);
      else passed++;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({bin, gray, wrap} !== {4'b0000, 4'b0000, 1'b0})
         $display("FAIL mid_async_rst: bin/gray/wrap=%b/%b/%b expected 0000/0000/0", bin, gray, wrap);
      else passed++;
      tick();
      rst = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      total++;
      if ({bin, gray, wrap} !== {4'b0001, 4'b0001, 1'b0})
         $display("FAIL mid_resume: bin/gray/wrap=%b/%b/%b expected 0001/0001/0", bin, gray, wrap);
      else passed++;
      total++;
      if ({bin5, gray5} !== {4'b0110, 4'b0101})
         $display("FAIL mid_resume_init5: bin/gray=%b/%b expected 0110/0101", bin5, gray5);
      else passed++;
      en = 1'b0;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_up_count();
      test_down_count();
      test_load();
      test_priority_hold();
      test_reset_mid_count();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_gray_counter
